// File: rtl/uio_bus_arbiter_if.sv
// Shared uio bus bundle between the requesters and the round-robin arbiter.
// The slave modport is the arbiter's view; master is the requester/pad side.
interface uio_bus_arbiter_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   wr;
  logic [NREQ*8-1:0] wdata;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        uio_in;
  logic [7:0]        uio_out;
  logic [7:0]        uio_oe;
  logic [7:0]        rdata;
  logic              rvalid;
  logic              busy;

  modport slave (
    input  req, wr, wdata, uio_in,
    output gnt, uio_out, uio_oe, rdata, rvalid, busy
  );

  modport master (
    output req, wr, wdata, uio_in,
    input  gnt, uio_out, uio_oe, rdata, rvalid, busy
  );
endinterface

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner sequencing for the shared 8-bit uio port, with a burst cap
// and an undriven turnaround gap between successive owners.
//
// state  | meaning
// S_IDLE | no owner, bus undriven, waiting for ena and a request
// S_OWN  | r_owner holds the bus, r_cnt counts cycles of this grant
// S_TURN | bus released, r_tcnt counts remaining turnaround cycles
module uio_bus_arbiter #(
  parameter int NREQ       = 4,
  parameter int MAX_BURST  = 8,
  parameter int TURNAROUND = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  uio_bus_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int OW = $clog2(NREQ * 8);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_TURN = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_owner, w_owner_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt;
  logic [PW-1:0]   w_win;
  logic [7:0]      r_cnt, w_cnt_nxt;
  logic [2:0]      r_tcnt, w_tcnt_nxt;
  logic [NREQ-1:0] r_gnt;
  logic [7:0]      r_rdata;
  logic            r_rvalid;
  logic            w_any;
  logic            w_pick;
  logic            w_owner_req;
  logic            w_owner_wr;
  logic            w_drive;
  logic [OW-1:0]   w_wbase;
  logic [7:0]      w_wbyte;
  int              w_idx;

  function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] v);
    if (int'(v) == NREQ - 1) return '0;
    return v + 1'b1;
  endfunction

  assign w_any       = |bus.req;
  assign w_owner_req = bus.req[r_owner];
  assign w_owner_wr  = bus.wr[r_owner];
  assign w_wbase     = OW'({r_owner, 3'b000});
  assign w_wbyte     = bus.wdata[w_wbase +: 8];

  // Scan from the farthest slot back to ptr so the slot nearest ptr wins last.
  always_comb begin
    w_win = r_ptr;
    w_idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (bus.req[PW'(w_idx)]) w_win = PW'(w_idx);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_tcnt_nxt  = r_tcnt;
    w_pick      = 1'b0;

    case (r_state)
      S_IDLE: w_pick = 1'b1;
      S_OWN: begin
        if (!ena) begin
          w_state_nxt = S_IDLE;
        end else if (!w_owner_req || (r_cnt == 8'(MAX_BURST))) begin
          if (TURNAROUND == 0) begin
            w_pick = 1'b1;
          end else begin
            w_state_nxt = S_TURN;
            w_tcnt_nxt  = 3'(TURNAROUND);
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_TURN: begin
        if (!ena) begin
          w_state_nxt = S_IDLE;
        end else if (r_tcnt <= 3'd1) begin
          w_pick = 1'b1;
        end else begin
          w_tcnt_nxt = r_tcnt - 3'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Shared selection point: IDLE, end of turnaround, or zero-gap handover.
    if (w_pick) begin
      if (ena && w_any) begin
        w_state_nxt = S_OWN;
        w_owner_nxt = w_win;
        w_ptr_nxt   = inc_mod(w_win);
        w_cnt_nxt   = 8'd1;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_tcnt   <= '0;
      r_gnt    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_ptr    <= w_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_tcnt   <= w_tcnt_nxt;
      r_gnt    <= (w_state_nxt == S_OWN) ? (NREQ'(1) << w_owner_nxt) : '0;
      r_rdata  <= bus.uio_in;
      r_rvalid <= (r_state == S_OWN) && !w_owner_wr && ena;
    end
  end

  assign w_drive     = (r_state == S_OWN) && w_owner_wr;
  assign bus.uio_oe  = w_drive ? 8'hFF : 8'h00;
  assign bus.uio_out = w_drive ? w_wbyte : 8'h00;
  assign bus.gnt     = r_gnt;
  assign bus.rdata   = r_rdata;
  assign bus.rvalid  = r_rvalid;
  assign bus.busy    = (r_state != S_IDLE);
endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed checks of grant order, burst cap, turnaround, read return,
// ena/rst removal and the zero-gap single-cycle burst configuration.
module tb_uio_bus_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic ena;
  int   n_vec = 0;
  int   n_err = 0;

  uio_bus_arbiter_if #(.NREQ(4)) ifa ();
  uio_bus_arbiter_if #(.NREQ(4)) ifb ();

  uio_bus_arbiter #(.NREQ(4), .MAX_BURST(8), .TURNAROUND(1)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .bus(ifa)
  );
  uio_bus_arbiter #(.NREQ(4), .MAX_BURST(1), .TURNAROUND(0)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .bus(ifb)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    ifa.req = '0;
    ifb.req = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [3:0]  eg;
    logic [31:0] wd;
    int          o;
    rst = 1'b1;
    ena = 1'b1;
    ifa.req = 4'b1111; ifa.wr = 4'b1111; ifa.wdata = 32'h44332211; ifa.uio_in = 8'h55;
    ifb.req = '0; ifb.wr = '0; ifb.wdata = '0; ifb.uio_in = '0;
    wd = 32'h44332211;
    #12;
    n_vec++;
    if ({ifa.gnt, ifa.uio_oe, ifa.uio_out, ifa.rdata, ifa.rvalid, ifa.busy} !== 30'd0) begin
      n_err++;
      $display("FAIL reset_outputs: gnt=%b oe=%h out=%h rdata=%h rvalid=%b busy=%b, want all 0",
               ifa.gnt, ifa.uio_oe, ifa.uio_out, ifa.rdata, ifa.rvalid, ifa.busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int g = 0; g < 5; g++) begin
      o  = g % 4;
      eg = 4'b0001 << o;
      for (int c = 0; c < 8; c++) begin
        tick();
        n_vec++;
        if ({ifa.gnt, ifa.uio_oe, ifa.uio_out, ifa.busy} !== {eg, 8'hFF, wd[8*o +: 8], 1'b1}) begin
          n_err++;
          $display("FAIL rr_own g%0d c%0d: gnt=%b oe=%h out=%h busy=%b, want gnt=%b oe=ff out=%h busy=1",
                   g, c, ifa.gnt, ifa.uio_oe, ifa.uio_out, ifa.busy, eg, wd[8*o +: 8]);
        end
      end
      if (g < 4) begin
        tick();
        n_vec++;
        if ({ifa.gnt, ifa.uio_oe, ifa.busy} !== {4'b0000, 8'h00, 1'b1}) begin
          n_err++;
          $display("FAIL rr_gap g%0d: gnt=%b oe=%h busy=%b, want gnt=0000 oe=00 busy=1",
                   g, ifa.gnt, ifa.uio_oe, ifa.busy);
        end
      end
    end
    ifa.req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_single;
    do_reset();
    ifa.req = 4'b0100; ifa.wr = 4'b0100; ifa.wdata = 32'h00A50000;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_vec++;
      if ({ifa.gnt, ifa.uio_oe, ifa.uio_out} !== {4'b0100, 8'hFF, 8'hA5}) begin
        n_err++;
        $display("FAIL single_own c%0d: gnt=%b oe=%h out=%h, want gnt=0100 oe=ff out=a5",
                 c, ifa.gnt, ifa.uio_oe, ifa.uio_out);
      end
    end
    tick();
    n_vec++;
    if ({ifa.gnt, ifa.uio_oe, ifa.uio_out} !== {4'b0000, 8'h00, 8'h00}) begin
      n_err++;
      $display("FAIL single_gap: gnt=%b oe=%h out=%h, want gnt=0000 oe=00 out=00",
               ifa.gnt, ifa.uio_oe, ifa.uio_out);
    end
    tick();
    n_vec++;
    if ({ifa.gnt, ifa.uio_oe, ifa.uio_out} !== {4'b0100, 8'hFF, 8'hA5}) begin
      n_err++;
      $display("FAIL single_regrant: gnt=%b oe=%h out=%h, want gnt=0100 oe=ff out=a5",
               ifa.gnt, ifa.uio_oe, ifa.uio_out);
    end
    ifa.req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_short_read;
    logic [4:0] eg, er, eb;
    eg = 5'b00111;
    er = 5'b01110;
    eb = 5'b01111;
    do_reset();
    ifa.req = 4'b0010; ifa.wr = 4'b0000; ifa.uio_in = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) ifa.req = 4'b0000;
      tick();
      n_vec++;
      if ({ifa.gnt, ifa.rvalid, ifa.busy, ifa.uio_oe} !==
          {(eg[i] ? 4'b0010 : 4'b0000), er[i], eb[i], 8'h00}) begin
        n_err++;
        $display("FAIL short_read t%0d: gnt=%b rvalid=%b busy=%b oe=%h, want gnt=%b rvalid=%b busy=%b oe=00",
                 i, ifa.gnt, ifa.rvalid, ifa.busy, ifa.uio_oe,
                 (eg[i] ? 4'b0010 : 4'b0000), er[i], eb[i]);
      end
      if (er[i]) begin
        n_vec++;
        if (ifa.rdata !== 8'h3C) begin
          n_err++;
          $display("FAIL short_rdata t%0d: rdata=%h, want 3c", i, ifa.rdata);
        end
      end
    end
  endtask

  task automatic test_ena_drop;
    do_reset();
    ifa.req = 4'b0011; ifa.wr = 4'b0011; ifa.wdata = 32'h0000BBAA;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_vec++;
      if ({ifa.gnt, ifa.uio_oe, ifa.uio_out} !== {4'b0001, 8'hFF, 8'hAA}) begin
        n_err++;
        $display("FAIL ena_own c%0d: gnt=%b oe=%h out=%h, want gnt=0001 oe=ff out=aa",
                 c, ifa.gnt, ifa.uio_oe, ifa.uio_out);
      end
    end
    ena = 1'b0;
    tick();
    n_vec++;
    if ({ifa.gnt, ifa.uio_oe, ifa.busy} !== {4'b0000, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL ena_drop: gnt=%b oe=%h busy=%b, want gnt=0000 oe=00 busy=0",
               ifa.gnt, ifa.uio_oe, ifa.busy);
    end
    ena = 1'b1;
    tick();
    n_vec++;
    if ({ifa.gnt, ifa.uio_oe, ifa.uio_out} !== {4'b0010, 8'hFF, 8'hBB}) begin
      n_err++;
      $display("FAIL ena_resume_ptr: gnt=%b oe=%h out=%h, want gnt=0010 oe=ff out=bb",
               ifa.gnt, ifa.uio_oe, ifa.uio_out);
    end
    ifa.req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_async_rst;
    do_reset();
    ifa.req = 4'b0010; ifa.wr = 4'b0010; ifa.wdata = 32'h00005A00;
    tick();
    tick();
    n_vec++;
    if ({ifa.gnt, ifa.uio_oe, ifa.uio_out} !== {4'b0010, 8'hFF, 8'h5A}) begin
      n_err++;
      $display("FAIL arst_pre: gnt=%b oe=%h out=%h, want gnt=0010 oe=ff out=5a",
               ifa.gnt, ifa.uio_oe, ifa.uio_out);
    end
    #3;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({ifa.gnt, ifa.uio_oe, ifa.uio_out, ifa.busy} !== {4'b0000, 8'h00, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL arst_immediate: gnt=%b oe=%h out=%h busy=%b, want all 0",
               ifa.gnt, ifa.uio_oe, ifa.uio_out, ifa.busy);
    end
    ifa.req = 4'b0101; ifa.wr = 4'b0000;
    #1;
    rst = 1'b0;
    tick();
    n_vec++;
    if (ifa.gnt !== 4'b0001) begin
      n_err++;
      $display("FAIL arst_ptr: gnt=%b, want 0001", ifa.gnt);
    end
    ifa.req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_drop_before_win;
    do_reset();
    ifa.req = 4'b0011; ifa.wr = 4'b0000;
    tick();
    ifa.req = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) ifa.req = 4'b0000;
      n_vec++;
      if (ifa.gnt[1] !== 1'b0) begin
        n_err++;
        $display("FAIL drop_never_granted t%0d: gnt=%b, want gnt[1]=0", i, ifa.gnt);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] eg;
    logic [7:0] eo;
    do_reset();
    ifb.req = 4'b0011; ifb.wr = 4'b0011; ifb.wdata = 32'h00002211;
    for (int i = 0; i < 6; i++) begin
      tick();
      eg = (i % 2 == 1) ? 4'b0010 : 4'b0001;
      eo = (i % 2 == 1) ? 8'h22 : 8'h11;
      n_vec++;
      if ({ifb.gnt, ifb.uio_oe, ifb.uio_out} !== {eg, 8'hFF, eo}) begin
        n_err++;
        $display("FAIL b2b_alt t%0d: gnt=%b oe=%h out=%h, want gnt=%b oe=ff out=%h",
                 i, ifb.gnt, ifb.uio_oe, ifb.uio_out, eg, eo);
      end
    end
    ifb.req = 4'b0100; ifb.wr = 4'b0100; ifb.wdata = 32'h00330000;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if ({ifb.gnt, ifb.uio_oe, ifb.uio_out} !== {4'b0100, 8'hFF, 8'h33}) begin
        n_err++;
        $display("FAIL b2b_sole t%0d: gnt=%b oe=%h out=%h, want gnt=0100 oe=ff out=33",
                 i, ifb.gnt, ifb.uio_oe, ifb.uio_out);
      end
    end
    ifb.req = '0;
    tick();
    n_vec++;
    if ({ifb.gnt, ifb.busy} !== {4'b0000, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_idle: gnt=%b busy=%b, want gnt=0000 busy=0", ifb.gnt, ifb.busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_short_read();
    test_ena_drop();
    test_async_rst();
    test_drop_before_win();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
